// File: rtl/imem_loader.sv
// imem_loader: instruction-memory stage in front of the single-cycle core.
// A byte stream carries a 4-byte little-endian word count N followed by
// N little-endian program words. Those words are written into an internal
// word-addressed memory. Once the image is complete the block enters RUN,
// raises core_run and serves combinational instruction fetches.
module imem_loader #(
  parameter int          DEPTH = 1024,
  parameter int          AW    = 10,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          reload,
  input  logic [31:0]   instr_addr,
  output logic [31:0]   instr_data,
  output logic [31:0]   last_pc,
  output logic          core_run,
  output logic          load_err,
  output logic [AW:0]   words_loaded
);

  typedef enum logic [1:0] {
    ST_HDR  = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  // Byte lane counter. It is shared by the header phase and the word phase.
  logic [1:0]  r_byte_cnt;
  // Lanes 0..2 of the word being assembled. The header is assembled here too.
  logic [23:0] r_asm;
  // Program length N of the current load, and the count of words written so far.
  logic [AW:0] r_n;
  logic [AW:0] r_words;
  logic [31:0] r_last_pc;
  logic [31:0] r_mem [DEPTH];

  logic        w_fire;
  logic        w_last_byte;
  logic [31:0] w_word;
  logic        w_hdr_bad;
  logic [AW:0] w_words_inc;
  logic        w_mem_we;
  logic        w_reload_ok;

  assign in_ready     = (r_state == ST_HDR) || (r_state == ST_LOAD);
  assign w_fire       = in_valid && in_ready;
  assign w_last_byte  = w_fire && (r_byte_cnt == 2'd3);
  // The incoming byte completes the word as lane 3, which is bits 31:24.
  assign w_word       = {in_data, r_asm};
  assign w_hdr_bad    = (w_word == 32'd0) || (w_word > 32'(DEPTH));
  assign w_words_inc  = r_words + {{AW{1'b0}}, 1'b1};
  assign w_mem_we     = w_last_byte && (r_state == ST_LOAD);
  assign w_reload_ok  = reload && ((r_state == ST_RUN) || (r_state == ST_ERR));

  assign core_run     = (r_state == ST_RUN);
  assign load_err     = (r_state == ST_ERR);
  assign last_pc      = r_last_pc;
  assign words_loaded = r_words;

  // State register. rst has priority over everything, including reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_HDR;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode: header check, end-of-image detection and reload.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_HDR: begin
        if (w_last_byte) begin
          w_next_state = w_hdr_bad ? ST_ERR : ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_last_byte && (w_words_inc == r_n)) begin
          w_next_state = ST_RUN;
        end
      end
      ST_RUN, ST_ERR: begin
        if (w_reload_ok) begin
          w_next_state = ST_HDR;
        end
      end
      default: w_next_state = ST_HDR;
    endcase
  end

  // Datapath: byte lanes, word count, program length and last_pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byte_cnt <= 2'd0;
      r_asm      <= 24'd0;
      r_n        <= '0;
      r_words    <= '0;
      r_last_pc  <= 32'd0;
    end else begin
      case (r_state)
        ST_HDR: begin
          if (w_fire) begin
            if (r_byte_cnt == 2'd3) begin
              r_byte_cnt <= 2'd0;
              if (!w_hdr_bad) begin
                r_last_pc <= w_word - 32'd1;
                r_n       <= w_word[AW:0];
                r_words   <= '0;
              end
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              case (r_byte_cnt)
                2'd0:    r_asm[7:0]   <= in_data;
                2'd1:    r_asm[15:8]  <= in_data;
                2'd2:    r_asm[23:16] <= in_data;
                default: r_asm        <= r_asm;
              endcase
            end
          end
        end
        ST_LOAD: begin
          if (w_fire) begin
            if (r_byte_cnt == 2'd3) begin
              r_byte_cnt <= 2'd0;
              r_words    <= w_words_inc;
            end else begin
              r_byte_cnt <= r_byte_cnt + 2'd1;
              case (r_byte_cnt)
                2'd0:    r_asm[7:0]   <= in_data;
                2'd1:    r_asm[15:8]  <= in_data;
                2'd2:    r_asm[23:16] <= in_data;
                default: r_asm        <= r_asm;
              endcase
            end
          end
        end
        ST_RUN, ST_ERR: begin
          if (w_reload_ok) begin
            r_byte_cnt <= 2'd0;
            r_words    <= '0;
            r_last_pc  <= 32'd0;
          end
        end
        default: begin
          r_byte_cnt <= 2'd0;
        end
      endcase
    end
  end

  // Program memory write. It is never reset, so stale words survive rst.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_words[AW-1:0]] <= w_word;
    end
  end

  // Fetch port. Only addresses below N are served, and only while in RUN.
  always_comb begin
    instr_data = NOP;
    if ((r_state == ST_RUN) && (instr_addr < 32'(r_n))) begin
      instr_data = r_mem[instr_addr[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized self-checking bench for imem_loader. Expected
// fetch results come from an associative-array model of loaded programs.
module tb_imem_loader;

  localparam int          DEPTH = 1024;
  localparam int          AW    = 10;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic [31:0]   instr_addr;
  logic [31:0]   instr_data;
  logic [31:0]   last_pc;
  logic          core_run;
  logic          load_err;
  logic [AW:0]   words_loaded;

  int checks = 0;
  int errors = 0;

  logic [31:0] imgWords [$];
  logic [31:0] modelMem [int];
  int unsigned modelN = 0;
  bit          modelRun = 1'b0;

  imem_loader #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .reload       (reload),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .last_pc      (last_pc),
    .core_run     (core_run),
    .load_err     (load_err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Expected fetch result: a loaded word below N while running, NOP otherwise.
  function automatic logic [31:0] expFetch(input logic [31:0] a);
    if (modelRun && (a < modelN)) return modelMem[int'(a)];
    return NOP;
  endfunction

  // Commits the current image into the model after a successful load.
  task automatic commit_model(input int unsigned n);
    for (int i = 0; i < imgWords.size(); i++) modelMem[i] = imgWords[i];
    modelN   = n;
    modelRun = 1'b1;
  endtask

  // Offers one byte after an optional random gap and returns in_ready/core_run seen before the edge.
  task automatic push_byte(input logic [7:0] b, input int gapPct, output logic rdy, output logic runPre);
    while ($urandom_range(99) < gapPct) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    rdy      = in_ready;
    runPre   = core_run;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Streams a header of n followed by every word in imgWords.
  task automatic load_image(input logic [31:0] n, input int gapPct, output int rdyCount,
                            output logic runPre, output logic runPost);
    logic rdy;
    rdyCount = 0;
    runPre   = 1'b0;
    for (int j = 0; j < 4; j++) begin
      push_byte(n[8*j +: 8], gapPct, rdy, runPre);
      if (rdy) rdyCount++;
    end
    for (int i = 0; i < imgWords.size(); i++) begin
      for (int j = 0; j < 4; j++) begin
        push_byte(imgWords[i][8*j +: 8], gapPct, rdy, runPre);
        if (rdy) rdyCount++;
      end
    end
    runPost = core_run;
  endtask

  task automatic fetch(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    instr_addr = a;
    #1;
    d = instr_data;
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(posedge clk);
    #1;
    reload = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst      = 1'b0;
    modelRun = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    do_reset();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (core_run !== 1'b0) begin errors++; $display("[TB] FAIL reset_core_run got %b want 0", core_run); end
    checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_load_err got %b want 0", load_err); end
    checks++; if (words_loaded !== '0) begin errors++; $display("[TB] FAIL reset_words got %0d want 0", words_loaded); end
    checks++; if (last_pc !== 32'd0) begin errors++; $display("[TB] FAIL reset_last_pc got %h want 0", last_pc); end
    fetch(32'd0, d);
    checks++; if (d !== NOP) begin errors++; $display("[TB] FAIL reset_fetch got %h want %h", d, NOP); end
  endtask

  task automatic test_basic_load();
    int rc;
    logic pre, post;
    logic [31:0] d;
    imgWords = '{32'h00500093, 32'h00100113, 32'h002081B3};
    load_image(32'd3, 0, rc, pre, post);
    commit_model(3);
    checks++; if (rc != 16) begin errors++; $display("[TB] FAIL basic_ready_count got %0d want 16", rc); end
    checks++; if (pre !== 1'b0) begin errors++; $display("[TB] FAIL basic_run_early got %b want 0", pre); end
    checks++; if (post !== 1'b1) begin errors++; $display("[TB] FAIL basic_run_after got %b want 1", post); end
    checks++; if (last_pc !== 32'd2) begin errors++; $display("[TB] FAIL basic_last_pc got %h want 2", last_pc); end
    checks++; if (words_loaded !== 11'd3) begin errors++; $display("[TB] FAIL basic_words got %0d want 3", words_loaded); end
    fetch(32'd1, d);
    checks++; if (d !== 32'h00100113) begin errors++; $display("[TB] FAIL basic_fetch1 got %h want 00100113", d); end
    fetch(32'd3, d);
    checks++; if (d !== NOP) begin errors++; $display("[TB] FAIL basic_fetch3 got %h want %h", d, NOP); end
    for (int a = 0; a < 3; a++) begin
      fetch(32'(a), d);
      checks++; if (d !== expFetch(32'(a))) begin errors++; $display("[TB] FAIL basic_fetch_model addr %0d got %h want %h", a, d, expFetch(32'(a))); end
    end
    fetch(32'hFFFFFFFF, d);
    checks++; if (d !== NOP) begin errors++; $display("[TB] FAIL basic_fetch_ffff got %h want %h", d, NOP); end
    // Bytes offered in RUN must be ignored.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (3) begin
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL run_in_ready got %b want 0", in_ready); end
      checks++; if (words_loaded !== 11'd3 || core_run !== 1'b1) begin errors++; $display("[TB] FAIL run_ignore got words %0d run %b want 3 1", words_loaded, core_run); end
    end
    in_valid = 1'b0;
    fetch(32'd0, d);
    checks++; if (d !== expFetch(32'd0)) begin errors++; $display("[TB] FAIL run_ignore_fetch got %h want %h", d, expFetch(32'd0)); end
  endtask

  task automatic test_random_gaps();
    logic rdy, pre;
    logic [31:0] d;
    int accepted;
    pulse_reload();
    modelRun = 1'b0;
    checks++; if (core_run !== 1'b0) begin errors++; $display("[TB] FAIL gaps_reload_run got %b want 0", core_run); end
    for (int j = 0; j < 4; j++) begin
      logic [31:0] n;
      n = 32'd3;
      push_byte(n[8*j +: 8], 50, rdy, pre);
    end
    accepted = 0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 4; j++) begin
        push_byte(imgWords[i][8*j +: 8], 50, rdy, pre);
        accepted++;
        checks++; if (int'(words_loaded) != accepted / 4) begin errors++; $display("[TB] FAIL gaps_words after byte %0d got %0d want %0d", accepted, words_loaded, accepted / 4); end
      end
    end
    commit_model(3);
    checks++; if (last_pc !== 32'd2) begin errors++; $display("[TB] FAIL gaps_last_pc got %h want 2", last_pc); end
    for (int a = 0; a < 4; a++) begin
      fetch(32'(a), d);
      checks++; if (d !== expFetch(32'(a))) begin errors++; $display("[TB] FAIL gaps_fetch addr %0d got %h want %h", a, d, expFetch(32'(a))); end
    end
  endtask

  task automatic test_header_errors();
    logic [31:0] badN [3];
    logic rdy, pre;
    logic [31:0] d;
    badN[0] = 32'd0;
    badN[1] = 32'(DEPTH + 1);
    badN[2] = 32'(DEPTH + 2) + $urandom_range(1000000);
    pulse_reload();
    modelRun = 1'b0;
    for (int k = 0; k < 3; k++) begin
      for (int j = 0; j < 4; j++) begin
        push_byte(badN[k][8*j +: 8], 30, rdy, pre);
        if (j == 2) begin
          checks++; if (load_err !== 1'b0) begin errors++; $display("[TB] FAIL err_early n=%h got %b want 0", badN[k], load_err); end
        end
      end
      checks++; if (load_err !== 1'b1) begin errors++; $display("[TB] FAIL err_flag n=%h got %b want 1", badN[k], load_err); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL err_in_ready n=%h got %b want 0", badN[k], in_ready); end
      checks++; if (core_run !== 1'b0) begin errors++; $display("[TB] FAIL err_core_run n=%h got %b want 0", badN[k], core_run); end
      fetch(32'd0, d);
      checks++; if (d !== NOP) begin errors++; $display("[TB] FAIL err_fetch n=%h got %h want %h", badN[k], d, NOP); end
      pulse_reload();
      checks++; if (load_err !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL err_reload n=%h got err %b rdy %b want 0 1", badN[k], load_err, in_ready); end
    end
  endtask

  task automatic test_full_load();
    int rc;
    logic pre, post;
    logic [31:0] d;
    logic [31:0] a;
    imgWords.delete();
    for (int i = 0; i < DEPTH; i++) imgWords.push_back($urandom());
    load_image(32'(DEPTH), 10, rc, pre, post);
    commit_model(DEPTH);
    checks++; if (rc != 4 + 4 * DEPTH) begin errors++; $display("[TB] FAIL full_ready_count got %0d want %0d", rc, 4 + 4 * DEPTH); end
    checks++; if (post !== 1'b1) begin errors++; $display("[TB] FAIL full_run got %b want 1", post); end
    checks++; if (last_pc !== 32'(DEPTH - 1)) begin errors++; $display("[TB] FAIL full_last_pc got %h want %h", last_pc, 32'(DEPTH - 1)); end
    fetch(32'(DEPTH - 1), d);
    checks++; if (d !== imgWords[DEPTH - 1]) begin errors++; $display("[TB] FAIL full_fetch_last got %h want %h", d, imgWords[DEPTH - 1]); end
    fetch(32'hFFFFFFFF, d);
    checks++; if (d !== NOP) begin errors++; $display("[TB] FAIL full_fetch_ffff got %h want %h", d, NOP); end
    fetch(32'(DEPTH), d);
    checks++; if (d !== NOP) begin errors++; $display("[TB] FAIL full_fetch_depth got %h want %h", d, NOP); end
    for (int k = 0; k < 16; k++) begin
      a = 32'($urandom_range(DEPTH + 15));
      fetch(a, d);
      checks++; if (d !== expFetch(a)) begin errors++; $display("[TB] FAIL full_fetch_rand addr %0d got %h want %h", a, d, expFetch(a)); end
    end
  endtask

  task automatic test_reset_midload();
    logic rdy, pre, post;
    logic [31:0] d;
    logic [31:0] n;
    int rc;
    pulse_reload();
    modelRun = 1'b0;
    n = 32'd4;
    for (int j = 0; j < 4; j++) push_byte(n[8*j +: 8], 0, rdy, pre);
    for (int j = 0; j < 8; j++) push_byte(8'($urandom()), 20, rdy, pre);
    checks++; if (words_loaded !== 11'd2) begin errors++; $display("[TB] FAIL mid_words_before got %0d want 2", words_loaded); end
    do_reset();
    checks++; if (words_loaded !== '0) begin errors++; $display("[TB] FAIL mid_words got %0d want 0", words_loaded); end
    checks++; if (core_run !== 1'b0) begin errors++; $display("[TB] FAIL mid_core_run got %b want 0", core_run); end
    checks++; if (in_ready !== 1'b1 || load_err !== 1'b0) begin errors++; $display("[TB] FAIL mid_hdr got rdy %b err %b want 1 0", in_ready, load_err); end
    checks++; if (last_pc !== 32'd0) begin errors++; $display("[TB] FAIL mid_last_pc got %h want 0", last_pc); end
    fetch(32'd0, d);
    checks++; if (d !== NOP) begin errors++; $display("[TB] FAIL mid_fetch got %h want %h", d, NOP); end
    imgWords.delete();
    imgWords.push_back($urandom());
    load_image(32'd1, 0, rc, pre, post);
    commit_model(1);
    checks++; if (post !== 1'b1) begin errors++; $display("[TB] FAIL mid_n1_run got %b want 1", post); end
    checks++; if (last_pc !== 32'd0) begin errors++; $display("[TB] FAIL mid_n1_last_pc got %h want 0", last_pc); end
    for (int a = 0; a < 3; a++) begin
      fetch(32'(a), d);
      checks++; if (d !== expFetch(32'(a))) begin errors++; $display("[TB] FAIL mid_n1_fetch addr %0d got %h want %h", a, d, expFetch(32'(a))); end
    end
  endtask

  task automatic test_reload_in_run();
    logic rdy, pre;
    logic [31:0] d;
    logic [31:0] n;
    pulse_reload();
    modelRun = 1'b0;
    checks++; if (core_run !== 1'b0) begin errors++; $display("[TB] FAIL rl_core_run got %b want 0", core_run); end
    fetch(32'd0, d);
    checks++; if (d !== NOP) begin errors++; $display("[TB] FAIL rl_fetch_hdr got %h want %h", d, NOP); end
    imgWords.delete();
    imgWords.push_back($urandom());
    imgWords.push_back($urandom());
    n = 32'd2;
    for (int j = 0; j < 4; j++) push_byte(n[8*j +: 8], 40, rdy, pre);
    for (int j = 0; j < 4; j++) push_byte(imgWords[0][8*j +: 8], 40, rdy, pre);
    // A reload during LOAD must be ignored.
    pulse_reload();
    checks++; if (words_loaded !== 11'd1 || in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rl_ignored got words %0d rdy %b want 1 1", words_loaded, in_ready); end
    fetch(32'd0, d);
    checks++; if (d !== NOP) begin errors++; $display("[TB] FAIL rl_fetch_load got %h want %h", d, NOP); end
    for (int j = 0; j < 4; j++) push_byte(imgWords[1][8*j +: 8], 40, rdy, pre);
    commit_model(2);
    checks++; if (core_run !== 1'b1) begin errors++; $display("[TB] FAIL rl_run got %b want 1", core_run); end
    checks++; if (last_pc !== 32'd1) begin errors++; $display("[TB] FAIL rl_last_pc got %h want 1", last_pc); end
    for (int a = 0; a < 3; a++) begin
      fetch(32'(a), d);
      checks++; if (d !== expFetch(32'(a))) begin errors++; $display("[TB] FAIL rl_fetch addr %0d got %h want %h", a, d, expFetch(32'(a))); end
    end
  endtask

  // Runs every scenario in sequence and prints the summary.
  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = 8'd0;
    reload     = 1'b0;
    instr_addr = 32'd0;
    test_reset();
    test_basic_load();
    test_random_gaps();
    test_header_errors();
    test_full_load();
    test_reset_midload();
    test_reload_in_run();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
